// File: rtl/rcc_div_switch_ctrl.sv
// ---------------------------------------------------------------------------
// rcc_div_switch_ctrl
//
// Purpose: sequences glitch-safe ratio changes on the RCC dynamic clock
// divider (ratios 1/2/4/8/16/64/128/256/512). A request is accepted over a
// valid/ready handshake. The controller gates the divided clock off, waits
// for the gate to drain, drives the new div_sel code, waits for the divider
// to settle, then waits for div_en before re-opening the gate and
// returning a response.
//
// Optional feature macro: RCC_DIV_CTRL_STAT_EN
//   defined   : sw_cnt counts successful switches, err_sticky latches errors
//   undefined : sw_cnt and err_sticky are tied to 0, no statistics flops
//
// Ports:
//   i_clk      in   source clock (divider input clock)
//   rst        in   asynchronous active-high reset
//   req_vld    in   ratio change request valid
//   req_exp    in   [3:0] requested ratio as log2 (0..9, 5 unsupported)
//   req_rdy    out  high only in IDLE
//   rsp_vld    out  one-cycle completion pulse
//   rsp_err    out  qualifies rsp_vld: rejected or alignment timeout
//   busy       out  high whenever a switch sequence is in progress
//   div_sel    out  [3:0] select code to the divider
//   gate_en    out  downstream clock-gate enable
//   div_en     in   divider output-enable / phase alignment indication
//   sw_cnt     out  [15:0] completed switch count
//   err_sticky out  sticky error flag
// ---------------------------------------------------------------------------
module rcc_div_switch_ctrl #(
    parameter int GATE_DLY   = 4,
    parameter int SETTLE_CYC = 1024,
    parameter int ALIGN_TMO  = 1024,
    parameter int CNT_W      = 11
) (
    input  logic        i_clk,
    input  logic        rst,
    input  logic        req_vld,
    input  logic [3:0]  req_exp,
    output logic        req_rdy,
    output logic        rsp_vld,
    output logic        rsp_err,
    output logic        busy,
    output logic [3:0]  div_sel,
    output logic        gate_en,
    input  logic        div_en,
    output logic [15:0] sw_cnt,
    output logic        err_sticky
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_SETTLE = 2'd2,
        S_ALIGN  = 2'd3
    } state_t;

    // Counter reload values: a phase of N cycles loads N-1 and ends at 0.
    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_DLY - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ALIGN_LD  = CNT_W'(ALIGN_TMO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Supported exponents; 5 (divide by 32) has no divider tap.
    function automatic logic exp_valid(input logic [3:0] e);
        return (e <= 4'd9) && (e != 4'd5);
    endfunction

    function automatic logic [3:0] exp_code(input logic [3:0] e);
        logic [3:0] c;
        case (e)
            4'd1:    c = 4'b1000;
            4'd2:    c = 4'b1001;
            4'd3:    c = 4'b1010;
            4'd4:    c = 4'b1011;
            4'd6:    c = 4'b1100;
            4'd7:    c = 4'b1101;
            4'd8:    c = 4'b1110;
            4'd9:    c = 4'b1111;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    state_t           r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [3:0]       r_new_exp, w_new_exp_nxt;
    logic [3:0]       r_cur_exp, w_cur_exp_nxt;
    logic [3:0]       r_div_sel, w_div_sel_nxt;
    logic             r_gate_en, w_gate_en_nxt;
    logic             r_rsp_vld, w_rsp_vld_nxt;
    logic             r_rsp_err, w_rsp_err_nxt;

    // State and control/output registers
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cur_exp <= 4'd0;
            r_div_sel <= 4'b0000;
            r_gate_en <= 1'b1;
            r_rsp_vld <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_exp <= w_cur_exp_nxt;
            r_div_sel <= w_div_sel_nxt;
            r_gate_en <= w_gate_en_nxt;
            r_rsp_vld <= w_rsp_vld_nxt;
            r_rsp_err <= w_rsp_err_nxt;
        end
    end

    // Counter and latched exponent are only meaningful outside IDLE,
    // where they are always loaded before use, so they carry no reset.
    always_ff @(posedge i_clk) begin
        r_cnt     <= w_cnt_nxt;
        r_new_exp <= w_new_exp_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_new_exp_nxt = r_new_exp;
        w_cur_exp_nxt = r_cur_exp;
        w_div_sel_nxt = r_div_sel;
        w_gate_en_nxt = r_gate_en;
        w_rsp_vld_nxt = 1'b0;
        w_rsp_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_vld) begin
                    if (!exp_valid(req_exp)) begin
                        w_rsp_vld_nxt = 1'b1;
                        w_rsp_err_nxt = 1'b1;
                    end else if (req_exp == r_cur_exp) begin
                        w_rsp_vld_nxt = 1'b1;
                    end else begin
                        w_new_exp_nxt = req_exp;
                        w_gate_en_nxt = 1'b0;
                        w_cnt_nxt     = GATE_LD;
                        w_state_nxt   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (r_cnt == '0) begin
                    w_div_sel_nxt = exp_code(r_new_exp);
                    w_cur_exp_nxt = r_new_exp;
                    w_cnt_nxt     = SETTLE_LD;
                    w_state_nxt   = S_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = ALIGN_LD;
                    w_state_nxt = S_ALIGN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_ALIGN: begin
                // div_en is tested first so alignment on the final
                // timeout cycle still counts as success.
                if (div_en) begin
                    w_gate_en_nxt = 1'b1;
                    w_rsp_vld_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_gate_en_nxt = 1'b1;
                    w_rsp_vld_nxt = 1'b1;
                    w_rsp_err_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req_rdy = (r_state == S_IDLE);
    assign busy    = (r_state != S_IDLE);
    assign rsp_vld = r_rsp_vld;
    assign rsp_err = r_rsp_err;
    assign div_sel = r_div_sel;
    assign gate_en = r_gate_en;

`ifdef RCC_DIV_CTRL_STAT_EN
    logic [15:0] r_sw_cnt;
    logic        r_err_sticky;
    logic        w_sw_inc;

    assign w_sw_inc = (r_state == S_ALIGN) && div_en;

    // Statistics update together with the response they describe
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_sw_cnt     <= 16'd0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_sw_inc) begin
                r_sw_cnt <= r_sw_cnt + 16'd1;
            end
            if (w_rsp_vld_nxt && w_rsp_err_nxt) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign sw_cnt     = r_sw_cnt;
    assign err_sticky = r_err_sticky;
`else
    assign sw_cnt     = 16'd0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: doc/rcc_div_switch_ctrl.md
# rcc_div_switch_ctrl

- Sequences glitch-safe ratio changes on the 1/2/4/8/16/64/128/256/512 dynamic clock divider in the RCC.
- Accepts a ratio request over a valid/ready handshake and checks it against the supported ratio set.
- Gates the divided clock off downstream, drives the new `div_sel` code, waits for settling and phase alignment, then re-enables the gate and returns a response.
- Sits between the RCC register/DVFS logic and the divider plus its downstream clock gate.

## Interface

Parameters
- `GATE_DLY`, default 4: cycles between gate drop and `div_sel` update; minimum 1.
- `SETTLE_CYC`, default 1024: cycles `div_sel` is held before alignment check; minimum 1.
- `ALIGN_TMO`, default 1024: maximum cycles spent waiting for `div_en`; minimum 1.
- `CNT_W`, default 11: width of the shared down-counter; must hold the largest of the three parameters minus 1.

Ports
- `i_clk`  in  1: source clock, same clock as the divider input.
- `rst`  in  1: asynchronous, active-high reset.
- `req_vld`  in  1: ratio change request valid.
- `req_exp`  in  4: requested ratio as log2 (0..9); 5 (÷32) and 10..15 are unsupported.
- `req_rdy`  out  1: high only in IDLE.
- `rsp_vld`  out  1: one-cycle completion pulse.
- `rsp_err`  out  1: qualifies `rsp_vld`; 1 means rejected or timed out.
- `busy`  out  1: high in any state other than IDLE.
- `div_sel`  out  4: select code to the divider.
- `gate_en`  out  1: downstream clock-gate enable.
- `div_en`  in  1: divider output-enable/alignment indication.
- `sw_cnt`  out  16: count of completed switches (see Configuration).
- `err_sticky`  out  1: sticky error flag (see Configuration).

## Operation

Encoding of `req_exp` to `div_sel`:
- 0→0000, 1→1000, 2→1001, 3→1010, 4→1011, 6→1100, 7→1101, 8→1110, 9→1111.
- All other values are invalid.

Reset values:
- `div_sel`=0000, current exponent register=0, `gate_en`=1.
- `rsp_vld`=0, `rsp_err`=0, `busy`=0, `req_rdy`=1, `sw_cnt`=0, `err_sticky`=0.

FSM:
- **IDLE**: on `req_vld` & `req_rdy`:
  - invalid exponent → `rsp_vld`=1 with `rsp_err`=1; no change to `div_sel`/`gate_en`; stay in IDLE.
  - exponent equals current → `rsp_vld`=1 with `rsp_err`=0; no sequence; stay in IDLE.
  - otherwise → latch exponent, `gate_en`←0, counter←`GATE_DLY`-1, go to DRAIN.
- **DRAIN**: count down. At 0: `div_sel`←new code, current exponent←new, counter←`SETTLE_CYC`-1, go to SETTLE.
- **SETTLE**: count down. At 0: counter←`ALIGN_TMO`-1, go to ALIGN.
- **ALIGN**:
  - `div_en`=1 → `gate_en`←1, `rsp_vld`=1 with `rsp_err`=0, go to IDLE.
  - counter reaches 0 while `div_en`=0 → `gate_en`←1, `rsp_vld`=1 with `rsp_err`=1, go to IDLE. `div_sel` keeps the new code.
  - If `div_en` is high on the same cycle the counter reaches 0, success wins.

Other rules:
- `req_exp` is sampled only at acceptance; changes while `busy` are ignored.
- Requests held during `busy` stall (`req_rdy`=0) and are accepted on the first IDLE cycle.
- Reset asserted mid-sequence returns every output to its reset value immediately (asynchronous); no response is issued for the aborted request.

## Timing

Let T be the acceptance cycle (`req_vld` & `req_rdy` at a rising edge of `i_clk`).
- Invalid or same-ratio request: `rsp_vld` high during cycle T+1; `req_rdy` stays 1, so back-to-back requests are accepted.
- Valid change:
  - `gate_en`=0 and `busy`=1 from T+1.
  - `div_sel` changes at T+1+`GATE_DLY`.
  - First `div_en` sample at T+1+`GATE_DLY`+`SETTLE_CYC`.
  - If `div_en` is first seen at cycle A, then `gate_en`=1, `rsp_vld` pulses and `busy`=0 during A+1.
  - Timeout response at T+1+`GATE_DLY`+`SETTLE_CYC`+`ALIGN_TMO`.
- All outputs are registered; `req_rdy` is decoded from state.

## Configuration

`RCC_DIV_CTRL_STAT_EN`
- Defined:
  - `sw_cnt` increments by 1 on each successful full sequence (ALIGN success only) and wraps at 16'hFFFF→0.
  - `err_sticky` sets on any `rsp_err` pulse and clears only on reset.
- Not defined: `sw_cnt` is tied to 0, `err_sticky` is tied to 0, and no counter flops are present.

## Test plan

- **Reset**: assert `rst` → `div_sel`=0000, `gate_en`=1, `req_rdy`=1, `busy`=0.
- **Valid switch**: `req_exp`=4 with defaults and `div_en` tied 1 → `gate_en` low at T+1, `div_sel`=1011 at T+5, `rsp_vld` with `rsp_err`=0 at T+1030, `gate_en`=1 at T+1030.
- **Invalid requests**: `req_exp`=5, then `req_exp`=12 → each gives `rsp_vld` with `rsp_err`=1 at T+1, `div_sel` unchanged, `gate_en` stays 1.
- **Same ratio**: after the 4 switch, request `req_exp`=4 → `rsp_vld` with `rsp_err`=0 at T+1, `gate_en` never drops.
- **Alignment timeout**: `div_en` held 0 with `ALIGN_TMO`=8 → `rsp_err`=1 at T+1+4+1024+8, `gate_en`=1, `div_sel` holds the new code; with the macro defined, `err_sticky`=1.
- **Reset mid-sequence**: assert `rst` in SETTLE → outputs return to reset values immediately, no `rsp_vld`; a subsequent `req_exp`=9 completes with `div_sel`=1111.
